// File: rtl/cache_line_arbiter_pkg.sv
// Shared cache types: line/address widths and the line-port arbiter state encoding.
package cache_line_arbiter_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/cache_line_arbiter_chk.sv
// Protocol invariants of the line-port arbiter, observed on its registered outputs.
module cache_line_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic mem_read,
  input logic mem_write,
  input logic i_resp,
  input logic d_resp
);

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

  a_resp_exclusive: assert property (@(posedge clk) disable iff (rst) !(i_resp && d_resp));

  a_i_resp_pulse: assert property (@(posedge clk) disable iff (rst) i_resp |=> !i_resp);

  a_d_resp_pulse: assert property (@(posedge clk) disable iff (rst) d_resp |=> !d_resp);

  // The adaptor must see its request drop in the response cycle so it does not restart.
  a_quiet_on_resp: assert property (@(posedge clk) disable iff (rst)
                                    (i_resp || d_resp) |-> !(mem_read || mem_write));

endmodule

// File: rtl/cache_line_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one adaptor line port.
// D-cache wins by default; I-cache is guaranteed a grant after STARVE_LIMIT D grants.
module cache_line_arbiter
  import cache_line_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [LINE_W-1:0]   wdata_r, wdata_nxt_s;
  logic [LINE_W-1:0]   rdata_r, rdata_nxt_s;
  logic                op_write_r, op_write_nxt_s;
  logic [STARVE_W-1:0] starve_cnt_r, starve_cnt_nxt_s;
  logic                mem_read_r, mem_read_nxt_s;
  logic                mem_write_r, mem_write_nxt_s;
  logic                i_resp_r, i_resp_nxt_s;
  logic                d_resp_r, d_resp_nxt_s;

  logic d_req_s;
  logic starve_hit_s;
  logic grant_i_s;
  logic grant_d_s;
  logic serving_s;

  assign d_req_s      = d_read || d_write;
  assign starve_hit_s = (starve_cnt_r == STARVE_MAX);
  assign serving_s    = (state_r == SERVE_I) || (state_r == SERVE_D);

  // Grant decision, only meaningful while idle.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (i_read && (!d_req_s || starve_hit_s)) begin
        grant_i_s = 1'b1;
      end else if (d_req_s) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_i_s) begin
          state_nxt_s = SERVE_I;
        end else if (grant_d_s) begin
          state_nxt_s = SERVE_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          state_nxt_s = RESP_I;
        end else begin
          state_nxt_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          state_nxt_s = RESP_D;
        end else begin
          state_nxt_s = SERVE_D;
        end
      end
      RESP_I:  state_nxt_s = IDLE;
      RESP_D:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture at grant and line capture on a response that belongs to a live transaction.
  always_comb begin
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    op_write_nxt_s = op_write_r;
    rdata_nxt_s    = rdata_r;
    if (grant_i_s) begin
      addr_nxt_s     = i_address;
      op_write_nxt_s = 1'b0;
    end else if (grant_d_s) begin
      addr_nxt_s     = d_address;
      wdata_nxt_s    = d_wdata;
      op_write_nxt_s = d_write;
    end else begin
      addr_nxt_s     = addr_r;
    end
    if (serving_s && mem_resp) begin
      rdata_nxt_s = mem_rdata;
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // Starvation counter: counts D grants that overtook a waiting I request.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (grant_i_s) begin
      starve_cnt_nxt_s = {STARVE_W{1'b0}};
    end else if ((state_r == IDLE) && !i_read) begin
      starve_cnt_nxt_s = {STARVE_W{1'b0}};
    end else if (grant_d_s && (starve_cnt_r < STARVE_MAX)) begin
      starve_cnt_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Control outputs are decoded from the next state so they register alongside it.
  always_comb begin
    mem_read_nxt_s  = (state_nxt_s == SERVE_I) ||
                      ((state_nxt_s == SERVE_D) && !op_write_nxt_s);
    mem_write_nxt_s = (state_nxt_s == SERVE_D) && op_write_nxt_s;
    i_resp_nxt_s    = (state_nxt_s == RESP_I);
    d_resp_nxt_s    = (state_nxt_s == RESP_D);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      rdata_r      <= {LINE_W{1'b0}};
      op_write_r   <= 1'b0;
      starve_cnt_r <= {STARVE_W{1'b0}};
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      rdata_r      <= rdata_nxt_s;
      op_write_r   <= op_write_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      mem_read_r   <= mem_read_nxt_s;
      mem_write_r  <= mem_write_nxt_s;
      i_resp_r     <= i_resp_nxt_s;
      d_resp_r     <= d_resp_nxt_s;
    end
  end

  assign mem_address = addr_r;
  assign mem_wdata   = wdata_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign i_rdata     = rdata_r;
  assign d_rdata     = rdata_r;
  assign i_resp      = i_resp_r;
  assign d_resp      = d_resp_r;

  cache_line_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read_r),
    .mem_write (mem_write_r),
    .i_resp    (i_resp_r),
    .d_resp    (d_resp_r)
  );

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Scoreboard bench for cache_line_arbiter: directed client traffic, a behavioural adaptor,
// and a monitor that checks every client response against the expected queue.
module tb_cache_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_address;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  typedef struct {
    logic         is_i;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat    = 4;
  bit   spur_req = 1'b0;

  localparam logic [255:0] W1 = {8{32'h1234_5678}};
  localparam logic [255:0] W2 = {8{32'hFFFF_0000}};

  always #5 clk = ~clk;

  cache_line_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Line the adaptor model returns for a given address.
  function automatic logic [255:0] line_for(input logic [31:0] a);
    logic [255:0] l;
    if (a == 32'h0000_1040) l = {32{8'hA5}};
    else l = {8{a ^ 32'hC3C3_0000}};
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic is_i, input logic [31:0] a);
    exp_t e;
    e.is_i = is_i;
    e.addr = a;
    e.line = line_for(a);
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for the client's resp, then drop its request like a real cache would.
  task automatic serve(input logic is_i, input logic chk_w, input logic [255:0] w);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      tick;
      if (is_i ? i_resp : d_resp) begin
        chk("resp_mem_read_low", {255'd0, mem_read}, 256'd0);
        chk("resp_mem_write_low", {255'd0, mem_write}, 256'd0);
        if (is_i) i_read = 1'b0;
        else begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end
        done = 1'b1;
      end else if (chk_w && mem_write) begin
        chk("wdata_held", mem_wdata, w);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL serve_timeout: client is_i=%0b got no resp in 100 cycles, required one", is_i);
    end
    tick;
    chk("resp_one_cycle", {254'd0, i_resp, d_resp}, 256'd0);
  endtask

  // Adaptor model: answers after lat cycles of a held request; can inject a spurious resp.
  initial begin
    int  wait_cnt;
    bit  spur_ack;
    wait_cnt  = 0;
    spur_ack  = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = 256'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack  = spur_req;
        mem_resp  = 1'b1;
        mem_rdata = {256{1'b1}};
      end else if (mem_read || mem_write) begin
        if (wait_cnt >= lat - 1) begin
          mem_resp  = 1'b1;
          mem_rdata = line_for(mem_address);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a client response is presented.
  initial begin
    bit   prev_mem_resp;
    exp_t e;
    prev_mem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("mem_rw_exclusive", {255'd0, mem_read && mem_write}, 256'd0);
        chk("resp_exclusive", {255'd0, i_resp && d_resp}, 256'd0);
        if (i_resp || d_resp) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b, required no resp", i_resp, d_resp);
          end else begin
            e = exp_q.pop_front();
            chk("resp_client_is_i", {255'd0, i_resp}, {255'd0, e.is_i});
            chk("resp_addr", {224'd0, mem_address}, {224'd0, e.addr});
            chk("resp_rdata", i_resp ? i_rdata : d_rdata, e.line);
            chk("resp_after_mem_resp", {255'd0, prev_mem_resp}, 256'd1);
          end
        end
      end
      prev_mem_resp = mem_resp;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int resps;
    rst = 1'b1; i_read = 1'b0; i_address = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'd0; d_wdata = 256'd0;
    tick;
    tick;
    chk("rst_mem_read", {255'd0, mem_read}, 256'd0);
    chk("rst_mem_write", {255'd0, mem_write}, 256'd0);
    chk("rst_resps", {254'd0, i_resp, d_resp}, 256'd0);
    chk("rst_mem_address", {224'd0, mem_address}, 256'd0);
    chk("rst_rdata", i_rdata | d_rdata, 256'd0);
    rst = 1'b0;
    tick;

    // Lone I read, adaptor latency 6.
    lat = 6; i_address = 32'h0000_1040; i_read = 1'b1;
    expect_resp(1'b1, 32'h0000_1040);
    tick;
    chk("i_grant_mem_read", {255'd0, mem_read}, 256'd1);
    chk("i_grant_addr", {224'd0, mem_address}, {224'd0, 32'h0000_1040});
    chk("i_grant_no_write", {255'd0, mem_write}, 256'd0);
    serve(1'b1, 1'b0, 256'd0);
    chk("i_rdata_after", i_rdata, {32{8'hA5}});

    // D write-back; client data/address change after grant must not leak through.
    lat = 3; d_address = 32'h0000_2000; d_wdata = W1; d_write = 1'b1;
    expect_resp(1'b0, 32'h0000_2000);
    tick;
    chk("d_grant_mem_write", {255'd0, mem_write}, 256'd1);
    chk("d_grant_mem_read", {255'd0, mem_read}, 256'd0);
    chk("d_grant_addr", {224'd0, mem_address}, {224'd0, 32'h0000_2000});
    chk("d_grant_wdata", mem_wdata, W1);
    d_wdata = W2; d_address = 32'h0000_3000;
    serve(1'b0, 1'b1, W1);

    // Simultaneous requests: D first, idle gap, then I.
    lat = 2; d_wdata = 256'd0;
    i_address = 32'h0000_4000; d_address = 32'h0000_5000;
    i_read = 1'b1; d_read = 1'b1;
    expect_resp(1'b0, 32'h0000_5000);
    expect_resp(1'b1, 32'h0000_4000);
    serve(1'b0, 1'b0, 256'd0);
    chk("gap_mem_read", {255'd0, mem_read}, 256'd0);
    serve(1'b1, 1'b0, 256'd0);

    // Starvation: four D grants overtake I, then I, then D resumes.
    lat = 1; i_address = 32'h0000_6000; d_address = 32'h0000_7000;
    i_read = 1'b1; d_read = 1'b1;
    expect_resp(1'b0, 32'h0000_7000);
    expect_resp(1'b0, 32'h0000_7040);
    expect_resp(1'b0, 32'h0000_7080);
    expect_resp(1'b0, 32'h0000_70C0);
    expect_resp(1'b1, 32'h0000_6000);
    expect_resp(1'b0, 32'h0000_7100);
    expect_resp(1'b0, 32'h0000_7140);
    k = 1;
    resps = 0;
    for (int c = 0; c < 300 && resps < 7; c++) begin
      tick;
      if (d_resp) begin
        resps++;
        if (k < 6) begin
          d_address = 32'h0000_7000 + 32'(k * 64);
          k++;
        end else begin
          d_read = 1'b0;
        end
      end
      if (i_resp) begin
        resps++;
        i_read = 1'b0;
      end
    end
    chk("starve_resp_count", 256'(resps), 256'd7);

    // Reset in the middle of a D read.
    tick;
    lat = 20; d_address = 32'h0000_8000; d_wdata = {8{32'hDEAD_BEEF}}; d_read = 1'b1;
    tick;
    chk("pre_rst_serve_d", {255'd0, mem_read}, 256'd1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; d_read = 1'b0;
    chk("mid_rst_mem_rw", {254'd0, mem_read, mem_write}, 256'd0);
    chk("mid_rst_resps", {254'd0, i_resp, d_resp}, 256'd0);
    chk("mid_rst_mem_address", {224'd0, mem_address}, 256'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 256'd0);
    chk("mid_rst_i_rdata", i_rdata, 256'd0);
    chk("mid_rst_d_rdata", d_rdata, 256'd0);
    lat = 3; i_address = 32'h0000_9000; i_read = 1'b1;
    expect_resp(1'b1, 32'h0000_9000);
    tick;
    chk("post_rst_mem_read", {255'd0, mem_read}, 256'd1);
    chk("post_rst_addr", {224'd0, mem_address}, {224'd0, 32'h0000_9000});
    serve(1'b1, 1'b0, 256'd0);

    // Spurious mem_resp while idle is ignored.
    tick;
    spur_req = ~spur_req;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("spur_no_resp", {254'd0, i_resp, d_resp}, 256'd0);
    end
    chk("spur_i_rdata", i_rdata, line_for(32'h0000_9000));
    chk("spur_d_rdata", d_rdata, line_for(32'h0000_9000));

    tick;
    tick;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
